// File: rtl/bsg_sync_handshake_tx.sv
// rtl/bsg_sync_handshake_tx.sv - two-phase bundled-data transmit end with acknowledge synchronizer
module bsg_sync_handshake_tx #(
  parameter int width_p           = 64,
  parameter int ack_sync_stages_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic [width_p-1:0] oclk_data_o,
  output logic               oclk_req_o,
  input  logic               oclk_ack_i,
  output logic               error_o
);

  localparam logic [0:0] idle_s     = 1'b0;
  localparam logic [0:0] wait_ack_s = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [width_p-1:0]           data_q, data_d;
  logic                         req_q, req_d;
  logic [ack_sync_stages_p-1:0] sync_q, sync_d;
  logic                         error_q, error_d;
  logic                         ack_sync;
  logic                         accept;
  logic                         spurious;

  assign ack_sync = sync_q[ack_sync_stages_p-1];
  assign ready_o  = (state_q == idle_s) & ~reset_i;
  assign accept   = v_i & ready_o;

  // An ack toggle while idle means the receiver lost toggle parity with us.
  assign spurious = (state_q == idle_s) & (ack_sync != req_q) & ~reset_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    sync_d  = {sync_q[ack_sync_stages_p-2:0], oclk_ack_i};
    error_d = error_q | spurious;
    case (state_q)
      idle_s: begin
        if (accept) begin
          data_d  = data_i;
          req_d   = ~req_q;
          state_d = wait_ack_s;
        end
      end
      default: begin
        if (ack_sync == req_q) state_d = idle_s;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= idle_s;
      data_q  <= '0;
      req_q   <= 1'b0;
      sync_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      sync_q  <= sync_d;
      error_q <= error_d;
    end
  end

  assign oclk_data_o = data_q;
  assign oclk_req_o  = req_q;
  assign error_o     = (error_q | spurious) & ~reset_i;

endmodule

// File: tb/tb_bsg_sync_handshake_tx.sv
// tb/tb_bsg_sync_handshake_tx.sv - self-checking bench for bsg_sync_handshake_tx
module tb_bsg_sync_handshake_tx;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        v_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        ready_o;
  logic [63:0] oclk_data_o;
  logic        oclk_req_o;
  logic        oclk_ack_i = 1'b0;
  logic        error_o;

  bsg_sync_handshake_tx #(.width_p(64), .ack_sync_stages_p(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .oclk_data_o(oclk_data_o), .oclk_req_o(oclk_req_o),
    .oclk_ack_i(oclk_ack_i), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [63:0] data;
    logic        ack;
    logic        e_ready;
    logic        e_req;
    logic [63:0] e_data;
    logic        e_err;
  } vec_t;

  // Receiver model: captures on each req toggle, acks 5 cycles later.
  logic        rx_en = 1'b0;
  logic        rx_last_req = 1'b0;
  int          rx_cnt = 0;
  logic [63:0] rx_q[$];
  logic [63:0] prev_data = '0;
  logic        prev_req = 1'b0;
  int          data_chg = 0;

  always @(negedge clk_i) begin
    if (rx_en) begin
      if (!ready_o && oclk_data_o != prev_data && oclk_req_o == prev_req) data_chg++;
      if (oclk_req_o != rx_last_req) begin
        rx_last_req = oclk_req_o;
        rx_q.push_back(oclk_data_o);
        rx_cnt = 5;
      end else if (rx_cnt > 0) begin
        rx_cnt--;
        if (rx_cnt == 0) oclk_ack_i = rx_last_req;
      end
    end
    prev_data = oclk_data_o;
    prev_req  = oclk_req_o;
  end

  vec_t vecs[15];

  initial begin
    logic [63:0] dead;
    logic [63:0] held_data;
    logic        held_req;
    int          stall_bad;
    int          budget;
    dead = 64'hDEADBEEF_01234567;
    //          rst   v     data         ack   rdy   req   data         err
    vecs[0]  = '{1'b1, 1'b0, 64'h0,       1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 64'h0,       1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 64'h0,       1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 64'h0,       1'b0, 1'b1, 1'b0, 64'h0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, dead,        1'b0, 1'b0, 1'b1, dead,  1'b0};
    vecs[5]  = '{1'b0, 1'b0, 64'h0,       1'b1, 1'b0, 1'b1, dead,  1'b0};
    vecs[6]  = '{1'b0, 1'b0, 64'h0,       1'b1, 1'b0, 1'b1, dead,  1'b0};
    vecs[7]  = '{1'b0, 1'b0, 64'h0,       1'b1, 1'b1, 1'b1, dead,  1'b0};
    vecs[8]  = '{1'b0, 1'b0, 64'h0,       1'b1, 1'b1, 1'b1, dead,  1'b0};
    vecs[9]  = '{1'b0, 1'b0, 64'h0,       1'b0, 1'b1, 1'b1, dead,  1'b0};
    vecs[10] = '{1'b0, 1'b0, 64'h0,       1'b0, 1'b1, 1'b1, dead,  1'b1};
    vecs[11] = '{1'b0, 1'b0, 64'h0,       1'b0, 1'b1, 1'b1, dead,  1'b1};
    vecs[12] = '{1'b0, 1'b0, 64'h0,       1'b0, 1'b1, 1'b1, dead,  1'b1};
    vecs[13] = '{1'b1, 1'b0, 64'h0,       1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 64'h0,       1'b0, 1'b1, 1'b0, 64'h0, 1'b0};

    #1;
    for (int i = 0; i < 15; i++) begin
      reset_i    = vecs[i].rst;
      v_i        = vecs[i].v;
      data_i     = vecs[i].data;
      oclk_ack_i = vecs[i].ack;
      step();
      chk($sformatf("vec%0d ready", i), {63'b0, ready_o}, {63'b0, vecs[i].e_ready});
      chk($sformatf("vec%0d req", i), {63'b0, oclk_req_o}, {63'b0, vecs[i].e_req});
      chk($sformatf("vec%0d data", i), oclk_data_o, vecs[i].e_data);
      chk($sformatf("vec%0d err", i), {63'b0, error_o}, {63'b0, vecs[i].e_err});
    end

    // Back-to-back stream of 0..7 against the delayed receiver.
    rx_last_req = oclk_req_o;
    data_chg = 0;
    rx_en = 1'b1;
    for (int w = 0; w < 8; w++) begin
      data_i = 64'(w);
      v_i = 1'b1;
      budget = 0;
      while (!ready_o && budget < 50) begin
        step();
        budget++;
      end
      chk($sformatf("stream ready before word %0d", w), {63'b0, ready_o}, 64'd1);
      step();
    end
    v_i = 1'b0;
    budget = 0;
    while (!ready_o && budget < 50) begin
      step();
      budget++;
    end
    rx_en = 1'b0;
    chk("stream toggles", 64'(rx_q.size()), 64'd8);
    for (int w = 0; w < 8; w++)
      if (w < rx_q.size()) chk($sformatf("stream word %0d", w), rx_q[w], 64'(w));
    chk("stream data stable in wait", 64'(data_chg), 64'd0);
    chk("stream no error", {63'b0, error_o}, 64'd0);

    // Stall: no ack for 100 cycles.
    v_i = 1'b1;
    data_i = 64'hA5A5_0000_FFFF_1234;
    step();
    v_i = 1'b0;
    held_data = oclk_data_o;
    held_req  = oclk_req_o;
    chk("stall accepted data", held_data, 64'hA5A5_0000_FFFF_1234);
    stall_bad = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (ready_o !== 1'b0 || oclk_data_o !== held_data || oclk_req_o !== held_req) stall_bad++;
    end
    chk("stall held", 64'(stall_bad), 64'd0);
    oclk_ack_i = held_req;
    step();
    step();
    chk("stall ready after 2 edges", {63'b0, ready_o}, 64'd0);
    step();
    chk("stall ready after 3 edges", {63'b0, ready_o}, 64'd1);
    chk("stall no error", {63'b0, error_o}, 64'd0);

    // Reset mid-transfer, then a clean transfer.
    v_i = 1'b1;
    data_i = 64'h5;
    step();
    v_i = 1'b0;
    chk("mid accept data", oclk_data_o, 64'h5);
    chk("mid in wait", {63'b0, ready_o}, 64'd0);
    reset_i = 1'b1;
    step();
    chk("mid reset data", oclk_data_o, 64'h0);
    chk("mid reset req", {63'b0, oclk_req_o}, 64'd0);
    chk("mid reset err", {63'b0, error_o}, 64'd0);
    chk("mid reset ready", {63'b0, ready_o}, 64'd0);
    reset_i = 1'b0;
    oclk_ack_i = 1'b0;
    step();
    chk("post reset ready", {63'b0, ready_o}, 64'd1);
    v_i = 1'b1;
    data_i = 64'h6;
    step();
    v_i = 1'b0;
    chk("xfer6 data", oclk_data_o, 64'h6);
    chk("xfer6 req", {63'b0, oclk_req_o}, 64'd1);
    oclk_ack_i = 1'b1;
    step();
    step();
    chk("xfer6 busy", {63'b0, ready_o}, 64'd0);
    step();
    chk("xfer6 ready", {63'b0, ready_o}, 64'd1);
    chk("xfer6 no error", {63'b0, error_o}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
